queue_fifo: RTL and testbench

- Parametrised successor to the team's basic queue, and a drop-in buffer between producer/consumer stages on a single clock.
- Adds the following:
  - simultaneous push and pop in one cycle;
  - depth that need not be a power of two;
  - an occupancy count;
  - programmable almost-full and almost-empty flags;
  - sticky overflow and underflow error flags;
  - a selectable read mode: first-word-fall-through or registered.

---
 rtl/queue_fifo_if.sv | 34 +++
 rtl/queue_fifo.sv | 98 +++++++++
 tb/tb_queue_fifo.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/queue_fifo_if.sv
// Producer/consumer bundle for queue_fifo: push side, pop side, status and error flags.
// The fifo sits on the slave modport; the stage driving it uses master.
interface queue_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] wr_data;
  logic             we;
  logic             re;
  logic             clr_err;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_data, we, re, clr_err,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_data, we, re, clr_err,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/queue_fifo.sv
// Single-clock FIFO of any depth with occupancy count, threshold flags, sticky
// error flags and a choice of fall-through or registered read.
module queue_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 32,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter bit FWFT      = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  queue_fifo_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             overflow_q;
  logic             underflow_q;
  logic             full;
  logic             empty;
  logic             pop_ok;
  logic             push_ok;

  // Handshake: a push is taken when we is high and there is room, or a pop is
  // taken in the same cycle; a pop is taken when re is high and the fifo holds
  // data. Both decisions use the state before the clock edge.
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_ok  = bus.re & ~empty;
  assign push_ok = bus.we & (~full | pop_ok);

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CW'(AF_THRESH));
  assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  // Explicit wrap so non power-of-two depths never index past the array.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= ptr_next(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_next(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      // A new error in the same cycle as clr_err keeps the flag set.
      overflow_q  <= (bus.we & ~push_ok) | (overflow_q & ~bus.clr_err);
      underflow_q <= (bus.re & empty) | (underflow_q & ~bus.clr_err);
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign bus.rd_data  = mem[rd_ptr];
      assign bus.rd_valid = ~empty;
    end else begin : g_reg
      logic [WIDTH-1:0] rd_data_q;
      logic             rd_valid_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= pop_ok;
          if (pop_ok) rd_data_q <= mem[rd_ptr];
        end
      end

      assign bus.rd_data  = rd_data_q;
      assign bus.rd_valid = rd_valid_q;
    end
  endgenerate
endmodule

// File: tb/tb_queue_fifo.sv
// Directed bench for queue_fifo: a depth-5 fall-through instance and a depth-4
// registered-read instance share one clock and reset.
module tb_queue_fifo;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  queue_fifo_if #(.WIDTH(8), .DEPTH(5)) a_if ();
  queue_fifo_if #(.WIDTH(8), .DEPTH(4)) b_if ();

  queue_fifo #(.WIDTH(8), .DEPTH(5), .AF_THRESH(3), .AE_THRESH(2), .FWFT(1'b1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if)
  );

  queue_fifo #(.WIDTH(8), .DEPTH(4), .AF_THRESH(2), .AE_THRESH(1), .FWFT(1'b0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_op(input logic we, input logic re, input logic [7:0] d);
    a_if.we      = we;
    a_if.re      = re;
    a_if.wr_data = d;
    tick();
    a_if.we = 1'b0;
    a_if.re = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    a_if.we = 1'b0; a_if.re = 1'b0; a_if.wr_data = '0; a_if.clr_err = 1'b0;
    b_if.we = 1'b0; b_if.re = 1'b0; b_if.wr_data = '0; b_if.clr_err = 1'b0;
    reset = 1'b1;
    #12;
    chk("rst_empty", 32'(a_if.empty), 1);
    chk("rst_full", 32'(a_if.full), 0);
    chk("rst_ae", 32'(a_if.almost_empty), 1);
    chk("rst_af", 32'(a_if.almost_full), 0);
    chk("rst_count", 32'(a_if.count), 0);
    chk("rst_valid", 32'(a_if.rd_valid), 0);
    chk("rst_ovf", 32'(a_if.overflow), 0);
    chk("rst_unf", 32'(a_if.underflow), 0);
    chk("rst_b_data", 32'(b_if.rd_data), 0);
    chk("rst_b_valid", 32'(b_if.rd_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // 1: three pushes, fall-through head, three pops
    a_op(1'b1, 1'b0, 8'h11);
    chk("t1_count1", 32'(a_if.count), 1);
    chk("t1_valid", 32'(a_if.rd_valid), 1);
    chk("t1_head", 32'(a_if.rd_data), 32'h11);
    a_op(1'b1, 1'b0, 8'h22);
    chk("t1_count2", 32'(a_if.count), 2);
    a_op(1'b1, 1'b0, 8'h33);
    chk("t1_count3", 32'(a_if.count), 3);
    chk("t1_af", 32'(a_if.almost_full), 1);
    chk("t1_ae", 32'(a_if.almost_empty), 0);
    chk("t1_pop0", 32'(a_if.rd_data), 32'h11);
    a_op(1'b0, 1'b1, 8'h00);
    chk("t1_pop1", 32'(a_if.rd_data), 32'h22);
    a_op(1'b0, 1'b1, 8'h00);
    chk("t1_pop2", 32'(a_if.rd_data), 32'h33);
    a_op(1'b0, 1'b1, 8'h00);
    chk("t1_empty", 32'(a_if.empty), 1);
    chk("t1_valid0", 32'(a_if.rd_valid), 0);

    // 2: fill depth 5, overflow on push while full, drain in order
    for (int i = 1; i <= 5; i++) begin
      a_op(1'b1, 1'b0, 8'(i));
      chk("t2_count", 32'(a_if.count), 32'(i));
      chk("t2_af", 32'(a_if.almost_full), (i >= 3) ? 1 : 0);
    end
    chk("t2_full", 32'(a_if.full), 1);
    a_op(1'b1, 1'b0, 8'h06);
    chk("t2_ovf", 32'(a_if.overflow), 1);
    chk("t2_count_hold", 32'(a_if.count), 5);
    chk("t2_head_hold", 32'(a_if.rd_data), 1);
    a_if.clr_err = 1'b1;
    tick();
    a_if.clr_err = 1'b0;
    chk("t2_ovf_clr", 32'(a_if.overflow), 0);
    for (int i = 1; i <= 5; i++) begin
      chk("t2_drain", 32'(a_if.rd_data), 32'(i));
      a_op(1'b0, 1'b1, 8'h00);
    end
    chk("t2_empty", 32'(a_if.empty), 1);

    // 3: full with 1..5, six simultaneous push/pop across the wrap
    for (int i = 1; i <= 5; i++) a_op(1'b1, 1'b0, 8'(i));
    for (int i = 6; i <= 11; i++) begin
      chk("t3_pop", 32'(a_if.rd_data), 32'(i - 5));
      a_op(1'b1, 1'b1, 8'(i));
      chk("t3_count", 32'(a_if.count), 5);
      chk("t3_full", 32'(a_if.full), 1);
    end
    chk("t3_ovf", 32'(a_if.overflow), 0);
    for (int i = 7; i <= 11; i++) begin
      chk("t3_drain", 32'(a_if.rd_data), 32'(i));
      a_op(1'b0, 1'b1, 8'h00);
    end
    chk("t3_empty", 32'(a_if.empty), 1);

    // 4: push+pop on empty takes the push, flags underflow
    a_op(1'b1, 1'b1, 8'hAA);
    chk("t4_count", 32'(a_if.count), 1);
    chk("t4_unf", 32'(a_if.underflow), 1);
    chk("t4_ovf", 32'(a_if.overflow), 0);
    a_if.clr_err = 1'b1;
    tick();
    a_if.clr_err = 1'b0;
    chk("t4_unf_clr", 32'(a_if.underflow), 0);
    chk("t4_head", 32'(a_if.rd_data), 32'hAA);
    a_op(1'b0, 1'b1, 8'h00);
    chk("t4_empty", 32'(a_if.empty), 1);

    // set-wins: pop on empty together with clr_err
    a_if.clr_err = 1'b1;
    a_op(1'b0, 1'b1, 8'h00);
    a_if.clr_err = 1'b0;
    chk("t4_set_wins", 32'(a_if.underflow), 1);

    // 6: async reset mid-cycle with three entries and a sticky flag
    for (int i = 1; i <= 3; i++) a_op(1'b1, 1'b0, 8'(i));
    chk("t6_count3", 32'(a_if.count), 3);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_empty", 32'(a_if.empty), 1);
    chk("t6_count", 32'(a_if.count), 0);
    chk("t6_valid", 32'(a_if.rd_valid), 0);
    chk("t6_unf", 32'(a_if.underflow), 0);
    chk("t6_af", 32'(a_if.almost_full), 0);
    #1;
    reset = 1'b0;
    a_op(1'b1, 1'b0, 8'h07);
    chk("t6_first", 32'(a_if.rd_data), 32'h07);
    chk("t6_count1", 32'(a_if.count), 1);

    // 5: registered read on the depth-4 instance
    b_if.we = 1'b1;
    b_if.wr_data = 8'h05;
    tick();
    chk("t5_valid_push", 32'(b_if.rd_valid), 0);
    b_if.wr_data = 8'h06;
    tick();
    b_if.we = 1'b0;
    chk("t5_count", 32'(b_if.count), 2);
    b_if.re = 1'b1;
    tick();
    chk("t5_valid1", 32'(b_if.rd_valid), 1);
    chk("t5_data1", 32'(b_if.rd_data), 32'h05);
    tick();
    b_if.re = 1'b0;
    chk("t5_valid2", 32'(b_if.rd_valid), 1);
    chk("t5_data2", 32'(b_if.rd_data), 32'h06);
    tick();
    chk("t5_valid_idle", 32'(b_if.rd_valid), 0);
    chk("t5_data_hold", 32'(b_if.rd_data), 32'h06);
    b_if.re = 1'b1;
    tick();
    b_if.re = 1'b0;
    chk("t5_unf", 32'(b_if.underflow), 1);
    chk("t5_valid_unf", 32'(b_if.rd_valid), 0);
    chk("t5_empty", 32'(b_if.empty), 1);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
